// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt request stage.
package irq_pkg;
  localparam int N  = 8;
  localparam int CW = 3;
  localparam logic [CW-1:0] CODE_RST = '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    CLEAR   = 2'd2
  } state_t;
endpackage

// File: rtl/irq_sync_edge.sv
// One request line: two-flop synchroniser, delay flop, and rising-edge pulse.
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic pulse
);
  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= line;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;
endmodule

// File: rtl/irq_request_stage.sv
// Synchronises eight request lines into a pending register, feeds the external
// priority encoder, and presents the returned code with a valid/ack handshake.
//
// state   | meaning
// IDLE    | waiting for a non-zero req_out; captures code_in when one appears
// PRESENT | int_valid high, int_code held until int_ack
// CLEAR   | one quiet cycle so req_out and the encoder reflect the cleared bit
module irq_request_stage
  import irq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  irq_in,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  req_out,
  input  logic [CW-1:0] code_in,
  output logic          int_valid,
  output logic [CW-1:0] int_code,
  input  logic          int_ack,
  output logic          any_pending
);
  logic [N-1:0]  edge_pulse;
  logic [N-1:0]  pending;
  logic [N-1:0]  clr;
  logic [CW-1:0] code_next;
  state_t        state, state_next;

  for (genvar i = 0; i < N; i++) begin : g_line
    irq_sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .line  (irq_in[i]),
      .pulse (edge_pulse[i])
    );
  end

  always_comb begin
    state_next = state;
    code_next  = int_code;
    clr        = '0;
    case (state)
      IDLE: begin
        // Encoder output is meaningless (000) when nothing is requested.
        if (|req_out) begin
          state_next = PRESENT;
          code_next  = code_in;
        end
      end
      PRESENT: begin
        if (int_ack) begin
          clr[int_code] = 1'b1;
          state_next    = CLEAR;
        end
      end
      CLEAR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      int_code    <= CODE_RST;
      pending     <= '0;
      req_out     <= '0;
      any_pending <= 1'b0;
    end else begin
      state       <= state_next;
      int_code    <= code_next;
      // A new edge on the line being acknowledged must not be lost.
      pending     <= (pending & ~clr) | edge_pulse;
      req_out     <= pending & mask;
      any_pending <= |pending;
    end
  end

  assign int_valid = (state == PRESENT);
endmodule

// File: tb/tb_irq_request_stage.sv
// Self-checking bench: directed handshake scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the request stage.
module tb_irq_request_stage;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic [7:0] req_out;
  logic [2:0] code_in;
  logic       int_valid;
  logic [2:0] int_code;
  logic       int_ack;
  logic       any_pending;

  int checks = 0;
  int failures = 0;

  // Behavioural model: irq_in history, pending set, and handshake status.
  logic [7:0] m_last = '0, m_prev = '0, m_prev2 = '0;
  logic [7:0] m_pend = '0, m_req = '0;
  logic       m_any = 1'b0, m_valid = 1'b0, m_cool = 1'b0;
  logic [2:0] m_code = '0;

  irq_request_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_in      (irq_in),
    .mask        (mask),
    .req_out     (req_out),
    .code_in     (code_in),
    .int_valid   (int_valid),
    .int_code    (int_code),
    .int_ack     (int_ack),
    .any_pending (any_pending)
  );

  // Stand-in for the parent-level 8-to-3 priority encoder.
  always_comb begin
    code_in = 3'b000;
    for (int i = 0; i < 8; i++)
      if (req_out[i]) code_in = 3'(i);
  end

  always #5 clk = ~clk;

  function automatic logic [2:0] highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--)
      if (v[i]) return 3'(i);
    return 3'b000;
  endfunction

  task automatic tick();
    logic [7:0] rise, clr, n_pend, n_req, n_last;
    logic       n_any, n_valid, n_cool;
    logic [2:0] n_code;
    n_last = irq_in;
    if (!rst_n) begin
      n_last = '0; n_pend = '0; n_req = '0; n_any = 1'b0;
      n_valid = 1'b0; n_cool = 1'b0; n_code = '0;
    end else begin
      // A line counts as risen when seen high two samples ago but low three samples ago.
      rise    = m_prev & ~m_prev2;
      clr     = (m_valid && int_ack) ? 8'(1 << m_code) : 8'h00;
      n_pend  = (m_pend & ~clr) | rise;
      n_req   = m_pend & mask;
      n_any   = |m_pend;
      n_valid = m_valid;
      n_code  = m_code;
      n_cool  = 1'b0;
      if (m_valid) begin
        if (int_ack) begin
          n_valid = 1'b0;
          n_cool  = 1'b1;
        end
      end else if (!m_cool && m_req != 0) begin
        n_valid = 1'b1;
        n_code  = highest(m_req);
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_prev2 = '0; m_prev = '0;
    end else begin
      m_prev2 = m_prev; m_prev = m_last;
    end
    m_last = n_last; m_pend = n_pend; m_req = n_req; m_any = n_any;
    m_valid = n_valid; m_cool = n_cool; m_code = n_code;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; irq_in = '0; int_ack = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic ack_and_settle();
    int_ack = 1'b1; tick(); int_ack = 1'b0; tick(); tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irq_in = 8'hFF; mask = 8'hFF; int_ack = 1'b0;
    repeat (3) tick();
    checks++;
    if (req_out !== 8'h00 || int_valid !== 1'b0 || any_pending !== 1'b0 || int_code !== 3'b000) begin
      failures++;
      $display("FAIL reset_state: req=%h valid=%b any=%b code=%b, expected 00/0/0/000",
               req_out, int_valid, any_pending, int_code);
    end
    rst_n = 1'b1;
    // Edge 0 is the first edge sampling rst_n high; outputs stay quiet through edge 2.
    for (int e = 0; e < 3; e++) begin
      tick();
      checks++;
      if (req_out !== 8'h00 || int_valid !== 1'b0 || any_pending !== 1'b0) begin
        failures++;
        $display("FAIL reset_release_quiet e%0d: req=%h valid=%b any=%b, expected 00/0/0",
                 e, req_out, int_valid, any_pending);
      end
    end
    tick();
    checks++;
    if (req_out !== 8'hFF || any_pending !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_req: req=%h any=%b, expected ff/1", req_out, any_pending);
    end
    tick();
    checks++;
    if (int_valid !== 1'b1 || int_code !== 3'd7) begin
      failures++;
      $display("FAIL reset_release_code: valid=%b code=%0d, expected 1/7", int_valid, int_code);
    end
    do_reset();
  endtask

  task automatic test_single();
    mask = 8'hFF; irq_in = 8'h00; repeat (3) tick();
    irq_in = 8'h20;
    repeat (3) tick();
    checks++;
    if (req_out !== 8'h00 || int_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_k2: req=%h valid=%b, expected 00/0", req_out, int_valid);
    end
    tick();
    checks++;
    if (req_out !== 8'h20 || int_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_k3: req=%h valid=%b, expected 20/0", req_out, int_valid);
    end
    tick();
    checks++;
    if (int_valid !== 1'b1 || int_code !== 3'd5) begin
      failures++;
      $display("FAIL single_k4: valid=%b code=%0d, expected 1/5", int_valid, int_code);
    end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checks++;
    if (int_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_ack: valid=%b, expected 0", int_valid);
    end
    tick();
    checks++;
    if (req_out !== 8'h00 || int_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_a1: req=%h valid=%b, expected 00/0", req_out, int_valid);
    end
    tick();
    checks++;
    if (int_valid !== 1'b0 || any_pending !== 1'b0) begin
      failures++;
      $display("FAIL single_a2: valid=%b any=%b, expected 0/0", int_valid, any_pending);
    end
  endtask

  task automatic test_priority();
    irq_in = 8'h00; repeat (3) tick();
    irq_in = 8'h48;
    repeat (5) tick();
    checks++;
    if (int_valid !== 1'b1 || int_code !== 3'd6) begin
      failures++;
      $display("FAIL prio_first: valid=%b code=%0d, expected 1/6", int_valid, int_code);
    end
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    tick();
    checks++;
    if (req_out !== 8'h08 || int_valid !== 1'b0) begin
      failures++;
      $display("FAIL prio_a1: req=%h valid=%b, expected 08/0", req_out, int_valid);
    end
    tick();
    checks++;
    if (int_valid !== 1'b1 || int_code !== 3'd3) begin
      failures++;
      $display("FAIL prio_second: valid=%b code=%0d, expected 1/3", int_valid, int_code);
    end
    ack_and_settle();
  endtask

  task automatic test_mask();
    irq_in = 8'h00; mask = 8'h7F; repeat (3) tick();
    irq_in = 8'h80;
    repeat (5) tick();
    checks++;
    if (any_pending !== 1'b1 || req_out !== 8'h00 || int_valid !== 1'b0) begin
      failures++;
      $display("FAIL mask_hold: any=%b req=%h valid=%b, expected 1/00/0",
               any_pending, req_out, int_valid);
    end
    mask = 8'hFF;
    tick();
    checks++;
    if (req_out !== 8'h80 || int_valid !== 1'b0) begin
      failures++;
      $display("FAIL mask_open_req: req=%h valid=%b, expected 80/0", req_out, int_valid);
    end
    tick();
    checks++;
    if (int_valid !== 1'b1 || int_code !== 3'd7) begin
      failures++;
      $display("FAIL mask_open_code: valid=%b code=%0d, expected 1/7", int_valid, int_code);
    end
    // Masking the presented line must not disturb the captured code or its clear.
    mask = 8'h7F;
    tick();
    checks++;
    if (int_valid !== 1'b1 || int_code !== 3'd7) begin
      failures++;
      $display("FAIL mask_change_present: valid=%b code=%0d, expected 1/7", int_valid, int_code);
    end
    ack_and_settle();
    checks++;
    if (any_pending !== 1'b0) begin
      failures++;
      $display("FAIL mask_cleared: any=%b, expected 0", any_pending);
    end
    mask = 8'hFF;
  endtask

  task automatic test_collision();
    irq_in = 8'h00; repeat (3) tick();
    irq_in = 8'h04;
    repeat (5) tick();
    checks++;
    if (int_valid !== 1'b1 || int_code !== 3'd2) begin
      failures++;
      $display("FAIL coll_present: valid=%b code=%0d, expected 1/2", int_valid, int_code);
    end
    irq_in = 8'h00; tick(); tick();
    irq_in = 8'h04; tick(); tick();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    checks++;
    if (int_valid !== 1'b0) begin
      failures++;
      $display("FAIL coll_ack: valid=%b, expected 0", int_valid);
    end
    tick();
    checks++;
    if (any_pending !== 1'b1 || req_out !== 8'h04) begin
      failures++;
      $display("FAIL coll_set_wins: any=%b req=%h, expected 1/04", any_pending, req_out);
    end
    tick();
    checks++;
    if (int_valid !== 1'b1 || int_code !== 3'd2) begin
      failures++;
      $display("FAIL coll_reassert: valid=%b code=%0d, expected 1/2", int_valid, int_code);
    end
  endtask

  task automatic test_reset_mid();
    checks++;
    if (int_valid !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre: valid=%b, expected 1", int_valid);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (int_valid !== 1'b0 || req_out !== 8'h00 || any_pending !== 1'b0 || int_code !== 3'b000) begin
      failures++;
      $display("FAIL rstmid: valid=%b req=%h any=%b code=%b, expected 0/00/0/000",
               int_valid, req_out, any_pending, int_code);
    end
    rst_n = 1'b1; irq_in = 8'h00;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    mask = 8'hFF;
    for (int c = 0; c < 600; c++) begin
      irq_in = irq_in ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
      int_ack = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
      checks++;
      if (req_out !== m_req || any_pending !== m_any) begin
        failures++;
        $display("FAIL rand_req c%0d: req=%h any=%b, expected %h/%b", c, req_out, any_pending, m_req, m_any);
      end
      checks++;
      if (int_valid !== m_valid || int_code !== m_code) begin
        failures++;
        $display("FAIL rand_hs c%0d: valid=%b code=%0d, expected %b/%0d", c, int_valid, int_code, m_valid, m_code);
      end
    end
    rst_n = 1'b1; int_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; mask = 8'hFF; int_ack = 1'b0;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_collision();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
